sl_preceptron_layer: RTL

SL_PRECEPTRON_LAYER -- requirements
Module: sl_preceptron_layer

---
 rtl/sl_preceptron_pkg.sv | 39 +++
 rtl/sl_preceptron_wbank.sv | 37 +++
 rtl/sl_preceptron_layer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sl_preceptron_pkg.sv
// Shared definitions for the perceptron layer.
// Contents: FSM state encoding, external weight address decode helpers
// (flat address = neuron*VECTOR_LENGTH + element), and saturation bounds for
// a signed accumulator of a given width.
package sl_preceptron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned neurons,
                                           input int unsigned vlen);
        return addr < (neurons * vlen);
    endfunction

    function automatic logic [31:0] addr_neuron(input logic [31:0] addr,
                                                input int unsigned vlen);
        return addr / vlen;
    endfunction

    function automatic logic [31:0] addr_elem(input logic [31:0] addr,
                                              input int unsigned vlen);
        return addr % vlen;
    endfunction

    // Largest / smallest value of a signed accumulator 'width' bits wide.
    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/sl_preceptron_wbank.sv
// Single-port weight RAM for one neuron, registered (1-cycle) read.
// Ports:
//   clk   - clock
//   en    - access enable
//   we    - write when en&we; otherwise en performs a read
//   addr  - element index
//   wdata - write data
//   rdata - read data, valid the cycle after a read access; holds otherwise
// Contents are not reset.
module sl_preceptron_wbank
    import sl_preceptron_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sl_preceptron_layer.sv
// Perceptron layer: buffers one input vector, then dot-products it against
// NUM_NEURONS weight banks in parallel and compares each sum to a threshold.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - input beat handshake; in_data lane0 = lowest element
//   mem_wen/mem_ren    - external weight write/read (served only in IDLE)
//   mem_addr/mem_wdata - flat weight address (neuron*VECTOR_LENGTH+element), data
//   mem_rdata/rvalid   - read data, one cycle after an accepted read
//   mem_err            - one-cycle pulse for a rejected access
//   cfg_threshold      - per-neuron signed thresholds, sampled on COMPUTE entry
//   status_sum/fire    - per-neuron final sum and sum>=threshold, held
//   status_valid       - one-cycle pulse when status updates
//   busy               - high outside IDLE
//   dbg_state          - current FSM state (state_t encoding)
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on state (high in IDLE and LOAD), never on in_valid.
// Build option: define SL_PRECEPTRON_SAT_EN for saturating (sticky per
// vector) accumulation; otherwise accumulation wraps two's-complement.
module sl_preceptron_layer
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int VECTOR_LENGTH  = 64,
    parameter int NUM_NEURONS    = 4,
    parameter int SUM_WIDTH      = 24,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] in_data,
    input  logic                                 mem_wen,
    input  logic                                 mem_ren,
    input  logic [MEM_ADDR_WIDTH-1:0]            mem_addr,
    input  logic [WEIGHTS_WIDTH-1:0]             mem_wdata,
    output logic [WEIGHTS_WIDTH-1:0]             mem_rdata,
    output logic                                 mem_rvalid,
    output logic                                 mem_err,
    input  logic [NUM_NEURONS*SUM_WIDTH-1:0]     cfg_threshold,
    output logic [NUM_NEURONS*SUM_WIDTH-1:0]     status_sum,
    output logic [NUM_NEURONS-1:0]               status_fire,
    output logic                                 status_valid,
    output logic                                 busy,
    output logic [1:0]                           dbg_state
);

    localparam int BEATS = VECTOR_LENGTH / DATA_IN_LANES;
    localparam int EW    = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CW    = $clog2(VECTOR_LENGTH + 1);
    localparam int PW    = DATA_IN_WIDTH + WEIGHTS_WIDTH;

    state_t                            state_q, state_d;
    logic [BW-1:0]                     beat_q;
    logic [CW-1:0]                     issue_q;
    logic                              acc_v_q;
    logic [EW-1:0]                     acc_idx_q;
    logic [NW-1:0]                     rd_nrn_q;
    logic signed [DATA_IN_WIDTH-1:0]   vbuf_q [VECTOR_LENGTH];
    logic signed [SUM_WIDTH-1:0]       acc_q  [NUM_NEURONS];
    logic signed [SUM_WIDTH-1:0]       acc_d  [NUM_NEURONS];
    logic signed [SUM_WIDTH-1:0]       thr_q  [NUM_NEURONS];
    logic signed [PW-1:0]              prod   [NUM_NEURONS];
    logic signed [SUM_WIDTH-1:0]       prod_ext [NUM_NEURONS];

    logic                              bank_en    [NUM_NEURONS];
    logic                              bank_we    [NUM_NEURONS];
    logic [EW-1:0]                     bank_addr  [NUM_NEURONS];
    logic [WEIGHTS_WIDTH-1:0]          bank_rdata [NUM_NEURONS];

    logic          beat_acc, issuing, last_acc, enter_compute;
    logic          mem_req, mem_ok;
    logic [NW-1:0] ext_nrn;
    logic [EW-1:0] ext_elem;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign beat_acc  = in_valid && in_ready;
    // One read per COMPUTE cycle until every element has been issued.
    assign issuing   = (state_q == ST_COMPUTE) && (issue_q < CW'(VECTOR_LENGTH));
    assign last_acc  = acc_v_q && (acc_idx_q == EW'(VECTOR_LENGTH - 1));

    assign mem_req  = mem_wen || mem_ren;
    assign mem_ok   = mem_req && (state_q == ST_IDLE) &&
                      addr_in_range(32'(mem_addr), NUM_NEURONS, VECTOR_LENGTH);
    assign ext_nrn  = NW'(addr_neuron(32'(mem_addr), VECTOR_LENGTH));
    assign ext_elem = EW'(addr_elem(32'(mem_addr), VECTOR_LENGTH));
    assign mem_rdata = bank_rdata[rd_nrn_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (beat_acc) state_d = (BEATS == 1) ? ST_COMPUTE : ST_LOAD;
            ST_LOAD:    if (beat_acc && (beat_q == BW'(BEATS - 1))) state_d = ST_COMPUTE;
            ST_COMPUTE: if (last_acc) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign enter_compute = (state_q != ST_COMPUTE) && (state_d == ST_COMPUTE);

    // Bank port mux: COMPUTE owns all banks; in IDLE the addressed bank
    // serves the external access. The two never overlap.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            bank_en[n]   = 1'b0;
            bank_we[n]   = 1'b0;
            bank_addr[n] = EW'(issue_q);
            if (issuing) begin
                bank_en[n] = 1'b1;
            end else if (mem_ok && (ext_nrn == NW'(n))) begin
                bank_en[n]   = 1'b1;
                bank_we[n]   = mem_wen;
                bank_addr[n] = ext_elem;
            end
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_bank
        sl_preceptron_wbank #(
            .DEPTH (VECTOR_LENGTH),
            .WIDTH (WEIGHTS_WIDTH),
            .AW    (EW)
        ) u_wbank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .addr  (bank_addr[g]),
            .wdata (mem_wdata),
            .rdata (bank_rdata[g])
        );
    end

`ifdef SL_PRECEPTRON_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = SUM_WIDTH'(sat_max(SUM_WIDTH));
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = SUM_WIDTH'(sat_min(SUM_WIDTH));
    logic [NUM_NEURONS-1:0]    sat_q, sat_d;
    logic signed [SUM_WIDTH:0] wide [NUM_NEURONS];
`endif

    // Multiply-accumulate on the weight returned for element acc_idx_q.
    always_comb begin
`ifdef SL_PRECEPTRON_SAT_EN
        sat_d = sat_q;
`endif
        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod[n]     = PW'(vbuf_q[acc_idx_q]) * PW'($signed(bank_rdata[n]));
            prod_ext[n] = SUM_WIDTH'(prod[n]);
`ifdef SL_PRECEPTRON_SAT_EN
            wide[n]  = (SUM_WIDTH+1)'(acc_q[n]) + (SUM_WIDTH+1)'(prod_ext[n]);
            acc_d[n] = acc_q[n];
            // Once clamped, a neuron holds its bound for the rest of the vector.
            if (!sat_q[n]) begin
                if (wide[n][SUM_WIDTH] != wide[n][SUM_WIDTH-1]) begin
                    sat_d[n] = 1'b1;
                    acc_d[n] = wide[n][SUM_WIDTH] ? SUM_MIN : SUM_MAX;
                end else begin
                    acc_d[n] = wide[n][SUM_WIDTH-1:0];
                end
            end
`else
            acc_d[n] = acc_q[n] + prod_ext[n];
`endif
        end
    end

`ifdef SL_PRECEPTRON_SAT_EN
    always_ff @(posedge clk) begin
        if (rst || enter_compute) begin
            sat_q <= '0;
        end else if (acc_v_q) begin
            sat_q <= sat_d;
        end
    end
`endif

    // Vector buffer holds data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            for (int l = 0; l < DATA_IN_LANES; l++) begin
                vbuf_q[EW'(int'(beat_q) * DATA_IN_LANES + l)] <=
                    in_data[l*DATA_IN_WIDTH +: DATA_IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            issue_q      <= '0;
            acc_v_q      <= 1'b0;
            acc_idx_q    <= '0;
            rd_nrn_q     <= '0;
            mem_rvalid   <= 1'b0;
            mem_err      <= 1'b0;
            status_valid <= 1'b0;
            status_sum   <= '0;
            status_fire  <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc_q[n] <= '0;
                thr_q[n] <= '0;
            end
        end else begin
            state_q      <= state_d;
            mem_err      <= mem_req && !mem_ok;
            mem_rvalid   <= mem_ok && mem_ren && !mem_wen;
            status_valid <= 1'b0;
            if (mem_ok) rd_nrn_q <= ext_nrn;

            if (beat_acc) begin
                beat_q <= (state_d == ST_COMPUTE) ? '0 : beat_q + BW'(1);
            end

            // Read pipeline: acc_v_q/acc_idx_q tag the bank data arriving next.
            acc_v_q   <= issuing;
            acc_idx_q <= EW'(issue_q);
            if (issuing) issue_q <= issue_q + CW'(1);

            if (enter_compute) begin
                issue_q <= '0;
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    acc_q[n] <= '0;
                    thr_q[n] <= cfg_threshold[n*SUM_WIDTH +: SUM_WIDTH];
                end
            end else if (acc_v_q) begin
                for (int n = 0; n < NUM_NEURONS; n++) acc_q[n] <= acc_d[n];
            end

            if (state_q == ST_DONE) begin
                status_valid <= 1'b1;
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    status_sum[n*SUM_WIDTH +: SUM_WIDTH] <= acc_q[n];
                    status_fire[n] <= (acc_q[n] >= thr_q[n]);
                end
            end
        end
    end

endmodule
